sobel_line_ctrl: RTL and testbench



---
 rtl/video_ctrl_pkg.sv | 16 +
 rtl/sobel_line_ctrl_sync_edge_det.sv | 22 ++
 rtl/sobel_line_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sobel_line_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_ctrl_pkg.sv
// Shared definitions for the video sequencing controllers: controller
// state encoding and default geometry parameters.
package video_ctrl_pkg;

    typedef enum logic [2:0] {
        SEEK,
        MEASURE,
        QUALIFY,
        ARM,
        LOCKED
    } ctrl_state_t;

    localparam int DEF_CNT_W    = 12;
    localparam int DEF_H_OFFSET = 3;

endpackage

// File: rtl/sobel_line_ctrl_sync_edge_det.sv
// Rising-edge detector for a sync input: registered previous level plus a
// combinational single-cycle rise pulse.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/sobel_line_ctrl.sv
// Sequencing controller for the Sobel/line-buffer chain: measures and
// qualifies the line period, then applies geometry and filter select at frame starts.
module sobel_line_ctrl
    import video_ctrl_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int H_OFFSET   = DEF_H_OFFSET,
    parameter int LOCK_LINES = 4,
    parameter int MIN_PERIOD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_in,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    input  logic             filter_en_req,
    output logic [CNT_W-1:0] h_size_cfg,
    output logic             locked,
    output logic             filter_sel,
    output logic             line_flush,
    output logic             err_pulse
);

    localparam int               MC_W    = $clog2(LOCK_LINES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] OFFS    = CNT_W'(H_OFFSET);
    localparam logic [MC_W-1:0]  LOCK_N  = MC_W'(LOCK_LINES);

    ctrl_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ref, w_ref_nxt;
    logic [MC_W-1:0]  r_match, w_match_nxt, w_match_inc;
    logic             w_hs_rise, w_vs_rise;
    logic             w_sat, w_hs_valid, w_same, w_bad;
    logic [CNT_W-1:0] w_hsize_nxt;
    logic             w_locked_nxt, w_fsel_nxt, w_flush_nxt, w_err_nxt;

    sync_edge_det u_hs_edge (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_sig  (h_sync_in),
        .o_rise (w_hs_rise)
    );

    sync_edge_det u_vs_edge (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_sig  (v_sync_in),
        .o_rise (w_vs_rise)
    );

    // Edges during active video or too soon after the last line start are glitches.
    assign w_sat       = (r_cnt == CNT_MAX);
    assign w_hs_valid  = w_hs_rise & ~de_in & ((r_state == SEEK) | (r_cnt >= MIN_P));
    assign w_same      = w_hs_valid & ~w_sat & (r_cnt == r_ref);
    assign w_bad       = (w_hs_valid & ~w_same) | w_sat;
    assign w_match_inc = r_match + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_hs_valid) begin
            r_cnt <= CNT_W'(1);
        end else if (!w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SEEK;
            r_ref      <= '0;
            r_match    <= '0;
            h_size_cfg <= '0;
            locked     <= 1'b0;
            filter_sel <= 1'b0;
            line_flush <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ref      <= w_ref_nxt;
            r_match    <= w_match_nxt;
            h_size_cfg <= w_hsize_nxt;
            locked     <= w_locked_nxt;
            filter_sel <= w_fsel_nxt;
            line_flush <= w_flush_nxt;
            err_pulse  <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ref_nxt   = r_ref;
        w_match_nxt = r_match;
        case (r_state)
            SEEK: begin
                if (w_hs_valid) begin
                    w_state_nxt = MEASURE;
                    w_match_nxt = '0;
                end
            end
            MEASURE: begin
                if (w_hs_valid) begin
                    w_state_nxt = QUALIFY;
                    w_ref_nxt   = r_cnt;
                    w_match_nxt = MC_W'(1);
                end
            end
            QUALIFY: begin
                if (w_same) begin
                    w_match_nxt = w_match_inc;
                    if (w_match_inc == LOCK_N) begin
                        w_state_nxt = ARM;
                    end
                end else if (w_hs_valid) begin
                    w_ref_nxt   = r_cnt;
                    w_match_nxt = MC_W'(1);
                end
            end
            ARM, LOCKED: begin
                // Period check outranks a coincident frame start.
                if (w_bad) begin
                    w_state_nxt = QUALIFY;
                    w_ref_nxt   = r_cnt;
                    w_match_nxt = MC_W'(1);
                end else if ((r_state == ARM) && w_vs_rise) begin
                    w_state_nxt = LOCKED;
                end
            end
            default: begin
                w_state_nxt = SEEK;
            end
        endcase
    end

    always_comb begin
        w_hsize_nxt  = h_size_cfg;
        w_locked_nxt = locked;
        w_fsel_nxt   = filter_sel;
        w_flush_nxt  = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            ARM: begin
                if (!w_bad && w_vs_rise) begin
                    w_hsize_nxt  = r_ref - OFFS;
                    w_locked_nxt = 1'b1;
                    w_fsel_nxt   = filter_en_req;
                    w_flush_nxt  = 1'b1;
                end
            end
            LOCKED: begin
                if (w_bad) begin
                    w_locked_nxt = 1'b0;
                    w_fsel_nxt   = 1'b0;
                    w_err_nxt    = 1'b1;
                    w_flush_nxt  = 1'b1;
                end else if (w_vs_rise) begin
                    w_fsel_nxt = filter_en_req;
                end
            end
            default: begin
            end
        endcase
    end

    a_min_above_offset: assert property (@(posedge clk) MIN_PERIOD > H_OFFSET);

    a_ref_above_offset: assert property (@(posedge clk) disable iff (rst)
        (r_state == ARM) |-> (r_ref >= OFFS));

endmodule

// File: tb/tb_sobel_line_ctrl.sv
// Scoreboard bench for sobel_line_ctrl: a timestamp-based reference model
// predicts every output change; a monitor matches the DUT against it.
module tb_sobel_line_ctrl;

    localparam int CNT_W      = 12;
    localparam int H_OFFSET   = 3;
    localparam int LOCK_LINES = 4;
    localparam int MIN_PERIOD = 8;
    localparam int SAT        = 4095;

    typedef struct packed {
        logic [11:0] hs;
        logic        lk;
        logic        fs;
        logic        fl;
        logic        er;
    } ovec_t;

    typedef struct {
        int    stamp;
        ovec_t v;
    } ev_t;

    logic             clk;
    logic             rst;
    logic             de_in;
    logic             h_sync_in;
    logic             v_sync_in;
    logic             filter_en_req;
    logic [CNT_W-1:0] h_size_cfg;
    logic             locked;
    logic             filter_sel;
    logic             line_flush;
    logic             err_pulse;

    sobel_line_ctrl #(
        .CNT_W      (CNT_W),
        .H_OFFSET   (H_OFFSET),
        .LOCK_LINES (LOCK_LINES),
        .MIN_PERIOD (MIN_PERIOD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .de_in         (de_in),
        .h_sync_in     (h_sync_in),
        .v_sync_in     (v_sync_in),
        .filter_en_req (filter_en_req),
        .h_size_cfg    (h_size_cfg),
        .locked        (locked),
        .filter_sel    (filter_sel),
        .line_flush    (line_flush),
        .err_pulse     (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_pass = 0;
    int    n_total = 0;
    int    edge_n = 0;
    bit    mon_en = 1'b0;
    ev_t   q[$];
    ovec_t mon_prev, mon_cur;
    ev_t   mon_ev;

    // Reference model state: time of last accepted line start, reference
    // period and how many consecutive lines have matched it.
    bit    m_hs_p = 0, m_vs_p = 0, m_first = 0, m_lk = 0;
    int    m_tlast = 0, m_ref = 0, m_run = 0;
    ovec_t m_out = '0;

    task automatic score(bit ok, string name, int unsigned act, int unsigned req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, req, edge_n);
    endtask

    task automatic model_edge();
        int    n, p;
        bit    hr, vr, acc, sat, bad;
        ovec_t nx;
        n  = edge_n + 1;
        nx = m_out;
        nx.fl = 1'b0;
        nx.er = 1'b0;
        if (rst) begin
            m_hs_p = 0; m_vs_p = 0; m_first = 0; m_lk = 0;
            m_run = 0; m_ref = 0;
            nx = '0;
        end else begin
            hr  = h_sync_in && !m_hs_p;
            vr  = v_sync_in && !m_vs_p;
            p   = n - m_tlast;
            if (p > SAT) p = SAT;
            acc = hr && !de_in && (!m_first || p >= MIN_PERIOD);
            sat = m_first && (p == SAT);
            bad = (acc && (p != m_ref || p == SAT)) || sat;
            if (!m_first) begin
                if (acc) m_first = 1;
            end else if (m_lk) begin
                if (bad) begin
                    m_lk = 0; nx.lk = 0; nx.fs = 0; nx.er = 1; nx.fl = 1;
                    m_ref = p; m_run = 1;
                end else if (vr) begin
                    nx.fs = filter_en_req;
                end
            end else if (m_run >= LOCK_LINES) begin
                if (bad) begin
                    m_ref = p; m_run = 1;
                end else if (vr) begin
                    m_lk = 1; nx.lk = 1; nx.fs = filter_en_req; nx.fl = 1;
                    nx.hs = 12'(m_ref - H_OFFSET);
                end
            end else if (acc) begin
                if (m_run > 0 && p == m_ref && p != SAT) m_run++;
                else begin
                    m_ref = p; m_run = 1;
                end
            end
            if (acc) m_tlast = n;
            m_hs_p = h_sync_in;
            m_vs_p = v_sync_in;
        end
        if (nx != m_out) q.push_back('{n, nx});
        m_out = nx;
    endtask

    task automatic step(bit hs, bit vs, bit de);
        h_sync_in = hs;
        v_sync_in = vs;
        de_in     = de;
        model_edge();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic send_line(int p, int vs_at, bit glitch, bit de_hs);
        for (int k = 0; k < p; k++) begin
            bit hs, vs, de;
            de = (k >= 9) && (k < p - 3);
            hs = (k == 0) || (glitch && (k == 2 || k == 4 || k == 6)) || (de_hs && k == p / 2);
            vs = (vs_at >= 0) && (k == vs_at || k == vs_at + 1);
            step(hs, vs, de);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_cur = {h_size_cfg, locked, filter_sel, line_flush, err_pulse};
            while (q.size() > 0 && q[0].stamp < edge_n) begin
                mon_ev = q.pop_front();
                score(1'b0, "missing_change", 32'(mon_prev), 32'(mon_ev.v));
            end
            if (mon_cur !== mon_prev) begin
                if (q.size() == 0) begin
                    score(1'b0, "unexpected_change", 32'(mon_cur), 32'(mon_prev));
                end else begin
                    mon_ev = q.pop_front();
                    score(mon_ev.stamp == edge_n, "change_edge", edge_n, mon_ev.stamp);
                    score(mon_ev.v === mon_cur, "output_vector", 32'(mon_cur), 32'(mon_ev.v));
                end
            end
            mon_prev = mon_cur;
        end
    end

    initial begin
        int p, nl;
        rst = 1'b1;
        filter_en_req = 1'b0;
        h_sync_in = 1'b0;
        v_sync_in = 1'b0;
        de_in = 1'b0;
        @(negedge clk);
        repeat (3) step(0, 0, 0);
        score(h_size_cfg == 12'd0, "reset_h_size_cfg", h_size_cfg, 0);
        score(locked == 1'b0, "reset_locked", locked, 0);
        score(filter_sel == 1'b0, "reset_filter_sel", filter_sel, 0);
        score(line_flush == 1'b0, "reset_line_flush", line_flush, 0);
        score(err_pulse == 1'b0, "reset_err_pulse", err_pulse, 0);
        mon_prev = {h_size_cfg, locked, filter_sel, line_flush, err_pulse};
        mon_en = 1'b1;
        rst = 1'b0;

        // Initial lock at P=83.
        repeat (5) send_line(83, -1, 0, 0);
        send_line(83, 40, 0, 0);
        score(locked == 1'b1, "lock83_locked", locked, 1);
        score(h_size_cfg == 12'd80, "lock83_h_size", h_size_cfg, 80);

        // Mid-frame request only takes effect at the next frame start.
        filter_en_req = 1'b1;
        send_line(83, -1, 0, 0);
        score(filter_sel == 1'b0, "fsel_held_midframe", filter_sel, 0);
        send_line(83, 30, 0, 0);
        score(filter_sel == 1'b1, "fsel_after_vsync", filter_sel, 1);

        // Glitch pulses and an hs edge during active video are ignored.
        send_line(83, -1, 1, 1);
        score(locked == 1'b1, "glitch_lock_held", locked, 1);
        send_line(83, -1, 0, 0);
        score(locked == 1'b1, "glitch_next_line", locked, 1);

        // Period change to 84 drops lock, then requalifies.
        send_line(84, -1, 0, 0);
        send_line(84, -1, 0, 0);
        score(locked == 1'b0, "p84_lock_lost", locked, 0);
        score(filter_sel == 1'b0, "p84_fsel_cleared", filter_sel, 0);
        repeat (2) send_line(84, -1, 0, 0);
        send_line(84, 40, 0, 0);
        score(locked == 1'b1, "p84_relocked", locked, 1);
        score(h_size_cfg == 12'd81, "p84_h_size", h_size_cfg, 81);

        // Missing h_sync: counter saturation drops lock.
        step(1, 0, 0);
        repeat (4999) step(0, 0, 0);
        score(locked == 1'b0, "sat_lock_lost", locked, 0);
        repeat (5) send_line(83, -1, 0, 0);
        send_line(83, 40, 0, 0);
        score(locked == 1'b1, "sat_relocked", locked, 1);
        score(h_size_cfg == 12'd80, "sat_relock_h_size", h_size_cfg, 80);

        // One-cycle reset while locked clears everything.
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        score({h_size_cfg, locked, filter_sel, line_flush, err_pulse} == 16'd0,
              "midrst_outputs", {h_size_cfg, locked, filter_sel, line_flush, err_pulse}, 0);
        repeat (3) send_line(83, -1, 0, 0);
        send_line(83, 40, 0, 0);
        score(locked == 1'b0, "midrst_not_yet_locked", locked, 0);
        send_line(83, -1, 0, 0);
        send_line(83, 40, 0, 0);
        score(locked == 1'b1, "midrst_relocked", locked, 1);

        // Randomized frames with occasional jitter, glitches and select changes.
        for (int f = 0; f < 20; f++) begin
            p  = $urandom_range(20, 60);
            nl = $urandom_range(5, 8);
            for (int l = 0; l < nl; l++) begin
                if ($urandom_range(0, 3) == 0) filter_en_req = $urandom_range(0, 1);
                send_line(($urandom_range(0, 9) == 0) ? p + 1 : p,
                          (l == nl - 1) ? int'($urandom_range(2, p - 4)) : -1,
                          $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            end
        end

        repeat (5) step(0, 0, 0);
        score(q.size() == 0, "pending_events", q.size(), 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
